// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: Moore state decode plus mem_ready/zero-qualified strobes.
// Optional performance counters are enabled by defining MULTICYCLE_CTRL_PERFCNT_EN.
module multicycle_controller #(
  parameter int unsigned CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 iord,
  output logic                 alu_src_b,
  output logic                 mem_to_reg,
  output logic                 pc_src,
  output logic [1:0]           alu_op,
  output logic [3:0]           state,
  output logic                 retire,
  output logic                 illegal
`ifdef MULTICYCLE_CTRL_PERFCNT_EN
  ,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instret_count
`endif
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXEC_R  = 4'd2,
    EXEC_I  = 4'd3,
    ADDR    = 4'd4,
    MEM_RD  = 4'd5,
    MEM_WR  = 4'd6,
    WB_ALU  = 4'd7,
    WB_MEM  = 4'd8,
    BRANCH  = 4'd9,
    ILLEGAL = 4'd10
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t cur_state;
  state_t nxt_state;
  logic   illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      if (nxt_state == ILLEGAL) begin
        illegal_q <= 1'b1;
      end
    end
  end

  always_comb begin
    nxt_state  = cur_state;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    alu_src_b  = 1'b0;
    mem_to_reg = 1'b0;
    pc_src     = 1'b0;
    alu_op     = 2'b00;
    retire     = 1'b0;
    case (cur_state)
      FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        if (mem_ready) begin
          nxt_state = DECODE;
        end
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE:           nxt_state = EXEC_R;
          OP_ITYPE:           nxt_state = EXEC_I;
          OP_LOAD, OP_STORE:  nxt_state = ADDR;
          OP_BRANCH:          nxt_state = BRANCH;
          default:            nxt_state = ILLEGAL;
        endcase
      end
      EXEC_R: begin
        alu_op    = 2'b10;
        nxt_state = WB_ALU;
      end
      EXEC_I: begin
        alu_src_b = 1'b1;
        alu_op    = 2'b11;
        nxt_state = WB_ALU;
      end
      ADDR: begin
        // Only loads and stores reach ADDR, so anything not a load is a store.
        alu_src_b = 1'b1;
        nxt_state = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          nxt_state = WB_MEM;
        end
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          nxt_state = FETCH;
        end
      end
      WB_ALU: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        nxt_state = FETCH;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        nxt_state  = FETCH;
      end
      BRANCH: begin
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_write  = zero;
        retire    = 1'b1;
        nxt_state = FETCH;
      end
      ILLEGAL: begin
        nxt_state = ILLEGAL;
      end
      default: begin
        nxt_state = FETCH;
      end
    endcase
  end

  assign state   = cur_state;
  assign illegal = illegal_q;

`ifdef MULTICYCLE_CTRL_PERFCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      if (cur_state != ILLEGAL) begin
        cycle_count <= cycle_count + CNT_WIDTH'(1);
      end
      if (retire) begin
        instret_count <= instret_count + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: expected per-instruction state traces are
// built from instruction-class latency rules; randomized opcodes, waits and don't-care inputs.
module tb_multicycle_controller;

  localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_EXEC_I = 3, S_ADDR = 4,
                 S_MEM_RD = 5, S_MEM_WR = 6, S_WB_ALU = 7, S_WB_MEM = 8, S_BRANCH = 9,
                 S_ILLEGAL = 10;
  localparam int T_R = 0, T_I = 1, T_LW = 2, T_SW = 3, T_BEQ = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, reg_write, mem_read, mem_write, iord;
  logic       alu_src_b, mem_to_reg, pc_src, retire, illegal;
  logic [1:0] alu_op;
  logic [3:0] state;
`ifdef MULTICYCLE_CTRL_PERFCNT_EN
  logic [63:0] cycle_count, instret_count;
`endif

  multicycle_controller #(.CNT_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .iord(iord), .alu_src_b(alu_src_b), .mem_to_reg(mem_to_reg),
    .pc_src(pc_src), .alu_op(alu_op), .state(state), .retire(retire), .illegal(illegal)
`ifdef MULTICYCLE_CTRL_PERFCNT_EN
    , .cycle_count(cycle_count), .instret_count(instret_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    bit rdy;
  } step_t;

  step_t trace[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc_no = 0;
  int    model_cyc = 0;
  int    model_inst = 0;
  int    seen_retire = 0;

  wire [12:0] dut_vec = {pc_write, ir_write, reg_write, mem_read, mem_write, iord,
                         alu_src_b, mem_to_reg, pc_src, alu_op, retire, illegal};

  function automatic logic [6:0] op_of(int t);
    case (t)
      T_R:     return 7'b0110011;
      T_I:     return 7'b0010011;
      T_LW:    return 7'b0000011;
      T_SW:    return 7'b0100011;
      default: return 7'b1100011;
    endcase
  endfunction

  // Outputs as listed per state in the control table; rdy/z only matter where named there.
  function automatic logic [12:0] exp_out(int st, bit rdy, bit z);
    bit pw = 0, irw = 0, rw = 0, mr = 0, mw = 0, io = 0, asb = 0, m2r = 0, ps = 0;
    bit ret = 0, ill = 0;
    logic [1:0] aop = 2'b00;
    case (st)
      S_FETCH:   begin mr = 1; irw = rdy; pw = rdy; end
      S_EXEC_R:  aop = 2'b10;
      S_EXEC_I:  begin asb = 1; aop = 2'b11; end
      S_ADDR:    asb = 1;
      S_MEM_RD:  begin mr = 1; io = 1; end
      S_MEM_WR:  begin mw = 1; io = 1; ret = rdy; end
      S_WB_ALU:  begin rw = 1; ret = 1; end
      S_WB_MEM:  begin rw = 1; m2r = 1; ret = 1; end
      S_BRANCH:  begin aop = 2'b01; ps = 1; pw = z; ret = 1; end
      S_ILLEGAL: ill = 1;
      default:   ;
    endcase
    return {pw, irw, rw, mr, mw, io, asb, m2r, ps, aop, ret, ill};
  endfunction

  // Waited phases: ready low for 'waits' cycles, then one ready-high cycle.
  task automatic push_wait(int st, int waits);
    for (int i = 0; i <= waits; i++) trace.push_back('{st, (i == waits)});
  endtask

  task automatic build_instr(int t, int fw, int mw);
    push_wait(S_FETCH, fw);
    trace.push_back('{S_DECODE, bit'($urandom)});
    case (t)
      T_R:  begin trace.push_back('{S_EXEC_R, bit'($urandom)}); trace.push_back('{S_WB_ALU, bit'($urandom)}); end
      T_I:  begin trace.push_back('{S_EXEC_I, bit'($urandom)}); trace.push_back('{S_WB_ALU, bit'($urandom)}); end
      T_LW: begin trace.push_back('{S_ADDR, bit'($urandom)}); push_wait(S_MEM_RD, mw);
                  trace.push_back('{S_WB_MEM, bit'($urandom)}); end
      T_SW: begin trace.push_back('{S_ADDR, bit'($urandom)}); push_wait(S_MEM_WR, mw); end
      default: trace.push_back('{S_BRANCH, bit'($urandom)});
    endcase
  endtask

  // Consumes the trace one cycle per entry; called and returning at a negedge.
  task automatic run_trace(logic [6:0] op, int zmode);
    step_t s;
    bit z;
    while (trace.size() > 0) begin
      s = trace.pop_front();
      z = (zmode < 0) ? bit'($urandom) : bit'(zmode);
      opcode = (s.st == S_FETCH) ? 7'($urandom) : op;
      mem_ready = s.rdy;
      zero = z;
      #1;
      n_checks++;
      if (state !== 4'(s.st)) begin
        n_fail++;
        $display("FAIL state cyc %0d: got %0d expected %0d", cyc_no, state, s.st);
      end
      n_checks++;
      if (dut_vec !== exp_out(s.st, s.rdy, z)) begin
        n_fail++;
        $display("FAIL outputs cyc %0d st %0d: got %b expected %b", cyc_no, s.st, dut_vec,
                 exp_out(s.st, s.rdy, z));
      end
      if (s.st != S_ILLEGAL) model_cyc++;
      if (exp_out(s.st, s.rdy, z) & 13'h2) model_inst++;
      if (retire === 1'b1) seen_retire++;
      cyc_no++;
      @(negedge clk);
    end
  endtask

  task automatic run_instr(int t, int fw, int mw, int zmode);
    build_instr(t, fw, mw);
    run_trace(op_of(t), zmode);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_cyc = 0;
    model_inst = 0;
  endtask

  task automatic check_counters(string name);
`ifdef MULTICYCLE_CTRL_PERFCNT_EN
    n_checks++;
    if (cycle_count !== 64'(model_cyc) || instret_count !== 64'(model_inst)) begin
      n_fail++;
      $display("FAIL %s counters: got cyc %0d inst %0d expected cyc %0d inst %0d", name,
               cycle_count, instret_count, model_cyc, model_inst);
    end
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got state %0d illegal %b expected 0 0", state, illegal);
    end
    n_checks++;
    if (dut_vec !== exp_out(S_FETCH, 1'b0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", dut_vec, exp_out(S_FETCH, 1'b0, 1'b0));
    end
    model_cyc = 0;
    model_inst = 0;
    check_counters("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    apply_reset();
    run_instr(T_I, 0, 0, -1);   // ADDI: 0,1,3,7
    run_instr(T_LW, 0, 2, -1);  // LW with two MEM_RD waits: 7 cycles
    run_instr(T_BEQ, 0, 0, 1);  // taken branch writes PC
    run_instr(T_BEQ, 0, 0, 0);  // not taken
    run_instr(T_SW, 1, 1, -1);
    run_instr(T_R, 2, 0, -1);
    check_counters("directed");
  endtask

  task automatic test_random();
    int n;
    apply_reset();
    seen_retire = 0;
    n = 30;
    for (int i = 0; i < n; i++)
      run_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), -1);
    n_checks++;
    if (seen_retire != n) begin
      n_fail++;
      $display("FAIL random_retire_count: got %0d expected %0d", seen_retire, n);
    end
    check_counters("random");
  endtask

  task automatic test_illegal();
    apply_reset();
    trace.push_back('{S_FETCH, 1'b1});
    trace.push_back('{S_DECODE, 1'b0});
    for (int i = 0; i < 20; i++) trace.push_back('{S_ILLEGAL, bit'($urandom)});
    run_trace(7'b1111111, -1);
    check_counters("illegal_frozen");
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (state !== 4'd0 || illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_async_reset: got state %0d illegal %b expected 0 0", state, illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_cyc = 0;
    model_inst = 0;
  endtask

  task automatic test_reset_mid_access();
    apply_reset();
    opcode = 7'b0100011;
    mem_ready = 1'b1;
    @(negedge clk);               // DECODE
    @(negedge clk);               // ADDR
    mem_ready = 1'b0;
    @(negedge clk);               // MEM_WR, waiting
    #1;
    n_checks++;
    if (mem_write !== 1'b1 || state !== 4'd6) begin
      n_fail++;
      $display("FAIL memwr_setup: got mem_write %b state %0d expected 1 6", mem_write, state);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_write !== 1'b0 || state !== 4'd0) begin
      n_fail++;
      $display("FAIL memwr_async_abort: got mem_write %b state %0d expected 0 0", mem_write, state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_cyc = 0;
    model_inst = 0;
    run_instr(T_I, 0, 0, -1);
    check_counters("restart");
  endtask

  task automatic test_perfcnt();
    apply_reset();
    for (int i = 0; i < 3; i++) run_instr(T_I, 0, 0, -1);
    run_instr(T_SW, 0, 0, -1);
`ifdef MULTICYCLE_CTRL_PERFCNT_EN
    n_checks++;
    if (instret_count !== 64'd4 || cycle_count !== 64'd16) begin
      n_fail++;
      $display("FAIL perfcnt_3addi_sw: got inst %0d cyc %0d expected 4 16", instret_count,
               cycle_count);
    end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_illegal();
    test_reset_mid_access();
    test_perfcnt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 64, width of the performance counters.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port opcode  input  7  instruction[6:0] from the datapath IR; valid from DECODE onward.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory completion handshake for the current read or write.
REQ-007 SHALL have outputs pc_write, ir_write, reg_write, mem_read, mem_write, iord, alu_src_b, mem_to_reg, pc_src, each  output  1  datapath strobe or select.
REQ-008 SHALL have port alu_op  output  2  00 add, 01 sub, 10 R-type funct decode, 11 I-type funct decode.
REQ-009 SHALL have ports state  output  4  current state code; retire  output  1  instruction-complete pulse; illegal  output  1  sticky illegal-opcode flag.

Function
REQ-010 SHALL implement a Moore FSM with registered state; outputs decode from state only, except where zero or mem_ready is named below.
REQ-011 SHALL use codes FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, ILLEGAL=10.
REQ-012 SHALL drive all strobes to 0 and alu_op to 00 in every state unless listed below.
REQ-013 FETCH SHALL drive mem_read=1, iord=0, alu_op=00; ir_write=pc_write=mem_ready with pc_src=0 (PC+4); it SHALL stay in FETCH until mem_ready=1, then go to DECODE.
REQ-014 DECODE (1 cycle) SHALL go to EXEC_R for 0110011, EXEC_I for 0010011, ADDR for 0000011 or 0100011, BRANCH for 1100011, and ILLEGAL for any other opcode.
REQ-015 EXEC_R SHALL drive alu_src_b=0, alu_op=10, then go to WB_ALU; EXEC_I SHALL drive alu_src_b=1, alu_op=11, then go to WB_ALU.
REQ-016 ADDR SHALL drive alu_src_b=1, alu_op=00, then go to MEM_RD for 0000011 and to MEM_WR for 0100011.
REQ-017 MEM_RD SHALL drive mem_read=1, iord=1, and hold until mem_ready, then go to WB_MEM; MEM_WR SHALL drive mem_write=1, iord=1, and hold until mem_ready, then go to FETCH with retire=1 on that cycle.
REQ-018 WB_ALU SHALL drive reg_write=1, mem_to_reg=0; WB_MEM SHALL drive reg_write=1, mem_to_reg=1; both SHALL assert retire and go to FETCH.
REQ-019 BRANCH SHALL drive alu_src_b=0, alu_op=01, pc_src=1, pc_write=zero, and retire=1, then go to FETCH.
REQ-020 ILLEGAL SHALL be absorbing until reset, with illegal=1 and all strobes 0.
REQ-021 With zero-wait memory, latency SHALL be R/I=4, LW=5, SW=4, BEQ=3 cycles; each mem_ready-low cycle adds exactly 1 cycle.
REQ-022 mem_ready SHALL be ignored in every state other than FETCH, MEM_RD, and MEM_WR.

Reset
REQ-023 rst_n=0 SHALL immediately force state=FETCH, illegal=0, and the counters to 0, without waiting for clk.
REQ-024 An assertion mid-transaction SHALL abandon the access; the FSM SHALL restart with FETCH on the first clk edge after rst_n rises.

Configuration
REQ-025 Macro MULTICYCLE_CTRL_PERFCNT_EN defined SHALL add outputs cycle_count and instret_count, each CNT_WIDTH bits.
REQ-026 cycle_count SHALL increment on every cycle outside ILLEGAL; instret_count SHALL increment on every retire cycle; both SHALL wrap modulo 2^CNT_WIDTH.
REQ-027 Without the macro, those ports and registers SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-028 ADDI (0010011), mem_ready=1 -> states 0,1,3,7; reg_write=1 and retire=1 only in cycle 4.
REQ-029 LW (0000011), mem_ready low 2 cycles in MEM_RD -> states 0,1,4,5,5,5,8; total 7 cycles.
REQ-030 BEQ (1100011) with zero=1 -> pc_write=1, pc_src=1 in BRANCH; with zero=0 -> pc_write=0; 3 cycles each.
REQ-031 opcode=1111111 -> ILLEGAL, illegal=1 held for 20 cycles; rst_n pulse low -> state=0, illegal=0 before the next clk edge.
REQ-032 With the macro, 3 ADDI plus 1 SW at zero wait -> instret_count=4, cycle_count=16; rst_n low in MEM_WR -> mem_write drops to 0 asynchronously.
